// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte to the device: clock inhibit, RTS, 8 data bits,
// odd parity and stop bit, then waits for the device ACK.
//
// Ports:
//   pclk, rst            system clock, synchronous active-low reset
//   tx_data, tx_valid    byte to send and its request strobe
//   tx_ready             high only while idle (byte accepted then)
//   ps2_clk_in/data_in   asynchronous pin levels
//   ps2_clk_oe/data_oe   open-drain pull-low enables (registered)
//   busy                 high whenever a transfer is in flight
//   tx_done, tx_error    one-cycle completion / failure pulses
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6500,
   parameter int TIMEOUT_CYCLES = 975000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int CNT_MAX =
      (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                        : INHIBIT_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t state;
   state_t state_n;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   sync_clk;
   logic                   sync_data;
   logic                   prev_clk;
   logic                   fall;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [3:0]    bitcnt;
   logic [3:0]    bitcnt_n;
   logic [9:0]    shreg;
   logic [9:0]    shreg_n;
   logic          clk_oe_n;
   logic          data_oe_n;
   logic          timeout;

   // Synchronizers reset to the idle (high) bus level so that leaving
   // reset never looks like a clock fall.
   always_ff @(posedge pclk) begin
      if (!rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         prev_clk  <= 1'b1;
      end else begin
         if (SYNC_STAGES > 1) begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
         end else begin
            clk_sync  <= {SYNC_STAGES{ps2_clk_in}};
            data_sync <= {SYNC_STAGES{ps2_data_in}};
         end
         prev_clk <= sync_clk;
      end
   end

   assign sync_clk  = clk_sync[SYNC_STAGES-1];
   assign sync_data = data_sync[SYNC_STAGES-1];
   assign fall      = prev_clk & ~sync_clk;

   // One counter serves both the inhibit interval and the RTS-to-ACK
   // watchdog; it is cleared on entry to INHIBIT and to RTS.
   assign timeout = (cnt == TO_LAST);

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bitcnt      <= '0;
         shreg       <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bitcnt      <= bitcnt_n;
         shreg       <= shreg_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bitcnt_n  = bitcnt;
      shreg_n   = shreg;
      clk_oe_n  = ps2_clk_oe;
      data_oe_n = ps2_data_oe;

      unique case (state)
         S_IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (tx_valid) begin
               shreg_n  = {1'b1, ~^tx_data, tx_data};
               bitcnt_n = '0;
               cnt_n    = '0;
               clk_oe_n = 1'b1;
               state_n  = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (cnt == INH_LAST) begin
               cnt_n     = '0;
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b1;
               state_n   = S_RTS;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         // The RTS fall is the first device clock: it already shifts
         // out bit 0, so RTS and SHIFT share the same action.
         S_RTS, S_SHIFT: begin
            cnt_n = cnt + CW'(1);
            if (timeout) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               state_n   = S_ERROR;
            end else if (fall) begin
               data_oe_n = ~shreg[bitcnt];
               bitcnt_n  = bitcnt + 4'd1;
               state_n   = (bitcnt == 4'd9) ? S_ACK : S_SHIFT;
            end
         end

         S_ACK: begin
            cnt_n = cnt + CW'(1);
            if (timeout) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               state_n   = S_ERROR;
            end else if (fall) begin
               if (sync_data) begin
                  clk_oe_n  = 1'b0;
                  data_oe_n = 1'b0;
                  state_n   = S_ERROR;
               end else begin
                  state_n = S_WAIT_IDLE;
               end
            end
         end

         S_WAIT_IDLE: begin
            cnt_n = cnt + CW'(1);
            if (timeout) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               state_n   = S_ERROR;
            end else if (sync_clk && sync_data) begin
               state_n = S_DONE;
            end
         end

         S_DONE: begin
            cnt_n    = '0;
            bitcnt_n = '0;
            state_n  = S_IDLE;
         end

         S_ERROR: begin
            cnt_n     = '0;
            bitcnt_n  = '0;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            state_n   = S_IDLE;
         end

         default: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            state_n   = S_IDLE;
         end
      endcase
   end

   assign tx_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign tx_done  = (state == S_DONE);
   assign tx_error = (state == S_ERROR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a PS/2
// device model, frame/result scoreboards and timing monitors.
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TO   = 3000;
   localparam int HALF = 100;

   localparam int M_ACK     = 0;
   localparam int M_NACK    = 1;
   localparam int M_TIMEOUT = 2;
   localparam int M_ABORT   = 3;

   logic       pclk     = 1'b0;
   logic       rst      = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   logic bfm_clk_low  = 1'b0;
   logic bfm_data_low = 1'b0;
   logic ps2_clk_in;
   logic ps2_data_in;

   // Wired-AND open-drain bus with pull-ups.
   assign ps2_clk_in  = ~(ps2_clk_oe | bfm_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | bfm_data_low);

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int bfm_mode  = M_ACK;
   int bfm_falls = 0;
   bit bfm_busy  = 1'b0;

   logic [7:0] frame_q[$];
   logic [1:0] res_q[$];

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .SYNC_STAGES(2)
   ) dut (
      .pclk(pclk),
      .rst(rst),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .ps2_clk_in(ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy(busy),
      .tx_done(tx_done),
      .tx_error(tx_error)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Device model: waits for request-to-send, then clocks 11 pulses,
   // samples the frame on rising edges and ACKs depending on mode.
   initial begin : bfm
      logic [9:0] got;
      logic [7:0] eb;
      int         m;
      int         k;
      forever begin
         @(negedge pclk);
         if (rst && ps2_clk_in && !ps2_data_in && !bfm_busy) begin
            bfm_busy  = 1'b1;
            m         = bfm_mode;
            bfm_falls = 0;
            got       = '0;
            if (m == M_TIMEOUT) begin
               k = 0;
               while (!ps2_data_in && k < 4 * TO) begin
                  @(negedge pclk);
                  k++;
               end
            end else begin
               repeat (10) @(negedge pclk);
               for (int i = 1; i <= 11; i++) begin
                  if (m == M_ABORT && i > 5) break;
                  bfm_clk_low = 1'b1;
                  bfm_falls   = i;
                  repeat (HALF) @(negedge pclk);
                  bfm_clk_low = 1'b0;
                  if (i <= 10) got[i-1] = ps2_data_in;
                  if (i == 10 && m == M_ACK) bfm_data_low = 1'b1;
                  repeat (HALF) @(negedge pclk);
               end
               bfm_data_low = 1'b0;
               if (m == M_ACK || m == M_NACK) begin
                  if (frame_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL frame: unexpected frame %03h", got);
                  end else begin
                     eb = frame_q.pop_front();
                     check("frame_data", {24'b0, got[7:0]}, {24'b0, eb});
                     check("frame_parity", {31'b0, got[8]},
                           ($countones(eb) % 2 == 0) ? 1 : 0);
                     check("frame_stop", {31'b0, got[9]}, 1);
                  end
               end
            end
            bfm_busy = 1'b0;
         end
      end
   end

   // Result scoreboard and timing monitor.
   logic prev_clk_oe = 1'b0;
   int   inh_start   = 0;
   int   rts_cyc     = 0;
   bit   pend_ready  = 1'b0;

   always @(negedge pclk) begin
      logic [1:0] exp;
      check("oe_exclusive", {31'b0, ps2_clk_oe & ps2_data_oe}, 0);
      if (pend_ready) begin
         check("ready_after_pulse", {31'b0, tx_ready}, 1);
         check("busy_after_pulse", {31'b0, busy}, 0);
         pend_ready = 1'b0;
      end
      if (ps2_clk_oe && !prev_clk_oe) inh_start = cyc;
      if (!ps2_clk_oe && prev_clk_oe && rst) begin
         check("inhibit_len", cyc - inh_start, INH);
         check("rts_data_oe", {31'b0, ps2_data_oe}, 1);
         rts_cyc = cyc;
      end
      prev_clk_oe = ps2_clk_oe;
      if (tx_done || tx_error) begin
         pend_ready = 1'b1;
         check("pulse_oe_clear", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
         if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result: unexpected pulse done=%0b error=%0b",
                     tx_done, tx_error);
         end else begin
            exp = res_q.pop_front();
            check("result", {30'b0, tx_done, tx_error}, {30'b0, exp});
         end
         if (tx_error && bfm_mode == M_TIMEOUT)
            check("timeout_cycles", cyc - rts_cyc, TO);
      end
   end

   task automatic wait_pulse(output bit ok);
      int k;
      k  = 0;
      ok = 1'b0;
      while (k < 6000) begin
         @(negedge pclk);
         if (tx_done || tx_error) begin
            ok = 1'b1;
            break;
         end
         k++;
      end
   endtask

   task automatic wait_bfm_idle();
      int k;
      k = 0;
      while (bfm_busy && k < 2000) begin
         @(negedge pclk);
         k++;
      end
      check("bfm_idle", {31'b0, bfm_busy}, 0);
      repeat (5) @(negedge pclk);
   endtask

   task automatic send(input logic [7:0] b, input int mode);
      bit ok;
      bfm_mode = mode;
      if (mode == M_ACK || mode == M_NACK) frame_q.push_back(b);
      res_q.push_back((mode == M_ACK) ? 2'b10 : 2'b01);
      @(negedge pclk);
      check("ready_before_send", {31'b0, tx_ready}, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge pclk);
      tx_valid = 1'b0;
      wait_pulse(ok);
      check("pulse_seen", {31'b0, ok}, 1);
      wait_bfm_idle();
   endtask

   task automatic abort_send(input logic [7:0] b);
      int k;
      bfm_mode = M_ABORT;
      @(negedge pclk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge pclk);
      tx_valid = 1'b0;
      k = 0;
      while (bfm_falls != 5 && k < 3000) begin
         @(negedge pclk);
         k++;
      end
      check("abort_fall5", bfm_falls, 5);
      repeat (50) @(negedge pclk);
      rst = 1'b0;
      @(posedge pclk);
      #1;
      check("abort_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
      check("abort_busy", {31'b0, busy}, 0);
      check("abort_pulses", {30'b0, tx_done, tx_error}, 0);
      @(negedge pclk);
      rst = 1'b1;
      wait_bfm_idle();
      repeat (20) @(negedge pclk);
   endtask

   task automatic back_to_back(input logic [7:0] b2);
      bit ok;
      int hi;
      int k;
      bfm_mode = M_ACK;
      frame_q.push_back(8'hF3);
      frame_q.push_back(b2);
      res_q.push_back(2'b10);
      res_q.push_back(2'b10);
      @(negedge pclk);
      tx_data  = 8'hF3;
      tx_valid = 1'b1;
      @(negedge pclk);
      check("b2b_first_accept", {31'b0, ps2_clk_oe}, 1);
      tx_data = b2;
      hi = 0;
      k  = 0;
      ok = 1'b0;
      while (k < 6000) begin
         if (tx_done) begin
            ok = 1'b1;
            break;
         end
         if (tx_ready) hi++;
         @(negedge pclk);
         k++;
      end
      check("b2b_done_seen", {31'b0, ok}, 1);
      check("b2b_ready_low", hi, 0);
      @(negedge pclk);
      check("b2b_idle_ready", {31'b0, tx_ready}, 1);
      @(negedge pclk);
      check("b2b_second_accept", {31'b0, ps2_clk_oe}, 1);
      tx_valid = 1'b0;
      wait_pulse(ok);
      check("b2b_second_pulse", {31'b0, ok}, 1);
      wait_bfm_idle();
   endtask

   initial begin : stim
      repeat (3) @(negedge pclk);
      check("rst_ready", {31'b0, tx_ready}, 1);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
      check("rst_pulses", {30'b0, tx_done, tx_error}, 0);
      rst = 1'b1;
      repeat (5) @(negedge pclk);

      send(8'hF4, M_ACK);
      send(8'h00, M_ACK);
      send(8'hFF, M_ACK);
      send(8'h01, M_ACK);
      send(8'($urandom), M_NACK);
      send(8'($urandom), M_TIMEOUT);
      abort_send(8'h5A);
      send(8'hFF, M_ACK);
      back_to_back(8'($urandom));
      for (int i = 0; i < 6; i++) begin
         send(8'($urandom),
              ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK);
      end

      check("res_q_drained", res_q.size(), 0);
      check("frame_q_drained", frame_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
